// File: rtl/zz_cpu.sv
// zz_cpu: single-issue 16-bit MIPS16-style CPU, instructions from switches.
// Data SRAM and UART share the Ram1 bus; Ram2 only exports the PC.
module zz_cpu (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] light,
  input  logic [15:0] l,
  output logic [17:0] Ram1Addr,
  inout  wire  [15:0] Ram1Data,
  output logic        Ram1OE,
  output logic        Ram1WE,
  output logic        Ram1EN,
  output logic [17:0] Ram2Addr,
  inout  wire  [15:0] Ram2Data,
  output logic        Ram2OE,
  output logic        Ram2WE,
  output logic        Ram2EN,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre,
  output logic        wrn,
  output logic        rdn
);

  logic [15:0] rf [8];
  logic [15:0] pc;
  logic [15:0] ir;

  logic [4:0]  op;
  logic [2:0]  rx_a;
  logic [2:0]  ry_a;
  logic [2:0]  rz_a;
  logic [15:0] rx_v;
  logic [15:0] ry_v;
  logic [15:0] sext5;
  logic [15:0] sext8;
  logic [15:0] sext11;
  logic [3:0]  sa;

  assign op     = ir[15:11];
  assign rx_a   = ir[10:8];
  assign ry_a   = ir[7:5];
  assign rz_a   = ir[4:2];
  assign rx_v   = rf[rx_a];
  assign ry_v   = rf[ry_a];
  assign sext5  = {{11{ir[4]}}, ir[4:0]};
  assign sext8  = {{8{ir[7]}}, ir[7:0]};
  assign sext11 = {{5{ir[10]}}, ir[10:0]};
  // a zero shift field encodes a shift by 8
  assign sa     = {(ir[4:2] == 3'd0), ir[4:2]};

  logic is_li;
  logic is_addiu;
  logic is_sll;
  logic is_sra;
  logic is_addu;
  logic is_subu;
  logic is_lw;
  logic is_sw;
  logic is_bnez;
  logic is_beqz;
  logic is_b;

  assign is_li    = (op == 5'b01101);
  assign is_addiu = (op == 5'b01001);
  assign is_sll   = (op == 5'b00110) && (ir[1:0] == 2'b00);
  assign is_sra   = (op == 5'b00110) && (ir[1:0] == 2'b11);
  assign is_addu  = (op == 5'b11100) && (ir[1:0] == 2'b01);
  assign is_subu  = (op == 5'b11100) && (ir[1:0] == 2'b11);
  assign is_lw    = (op == 5'b10011);
  assign is_sw    = (op == 5'b11011);
  assign is_bnez  = (op == 5'b00101);
  assign is_beqz  = (op == 5'b00100);
  assign is_b     = (op == 5'b00010);

  logic [15:0] ea;
  logic        uart_d;
  logic        uart_s;
  logic        sram;
  logic [15:0] rd_data;

  assign ea      = rx_v + sext5;
  assign uart_d  = (ea == 16'hBF00);
  assign uart_s  = (ea == 16'hBF01);
  assign sram    = !uart_d && !uart_s;
  assign rd_data = uart_s ? {14'b0, data_ready, tbre & tsre}
                          : Ram1Data;

  logic        we;
  logic [2:0]  wa;
  logic [15:0] wd;
  logic        taken;
  logic [15:0] off;
  logic [15:0] pc_next;

  always_comb begin
    we    = 1'b0;
    wa    = rx_a;
    wd    = 16'h0000;
    taken = 1'b0;
    off   = 16'h0000;
    unique case (1'b1)
      is_li: begin
        we = 1'b1;
        wd = {8'h00, ir[7:0]};
      end
      is_addiu: begin
        we = 1'b1;
        wd = rx_v + sext8;
      end
      is_sll: begin
        we = 1'b1;
        wd = ry_v << sa;
      end
      is_sra: begin
        we = 1'b1;
        wd = $signed(ry_v) >>> sa;
      end
      is_addu: begin
        we = 1'b1;
        wa = rz_a;
        wd = rx_v + ry_v;
      end
      is_subu: begin
        we = 1'b1;
        wa = rz_a;
        wd = rx_v - ry_v;
      end
      is_lw: begin
        we = 1'b1;
        wa = ry_a;
        wd = rd_data;
      end
      is_bnez: begin
        taken = (rx_v != 16'h0000);
        off   = sext8;
      end
      is_beqz: begin
        taken = (rx_v == 16'h0000);
        off   = sext8;
      end
      is_b: begin
        taken = 1'b1;
        off   = sext11;
      end
      default: ;
    endcase
  end

  assign pc_next = pc + 16'd1 + (taken ? off : 16'h0000);

  // write strobes only in the clk-low half; reset kills every strobe at once
  logic drive;

  assign drive    = rst && is_sw && (sram || uart_d);
  assign Ram1Data = drive ? ry_v : 16'hzzzz;
  assign Ram1Addr = {2'b00, ea};
  assign Ram1EN   = rst && (is_lw || is_sw) && uart_d;
  assign Ram1OE   = !(rst && is_lw && sram);
  assign Ram1WE   = !(rst && is_sw && sram && !clk);
  assign rdn      = !(rst && is_lw && uart_d);
  assign wrn      = !(rst && is_sw && uart_d && !clk);

  assign Ram2Addr = {2'b00, pc};
  assign Ram2Data = 16'hzzzz;
  assign Ram2OE   = 1'b1;
  assign Ram2WE   = 1'b1;
  assign Ram2EN   = 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        rf[i] <= 16'h0000;
      end
      pc    <= 16'h0000;
      ir    <= 16'h0800;
      light <= 16'h0000;
    end else begin
      ir <= l;
      pc <= pc_next;
      if (we) begin
        rf[wa] <= wd;
        light  <= wd;
      end
    end
  end

endmodule

// File: tb/tb_zz_cpu.sv
// tb_zz_cpu: directed instruction stream with a queued scoreboard;
// a monitor samples the DUT in each clock half and checks due entries.
module tb_zz_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] l = 16'h0800;
  logic        data_ready = 1'b0;
  logic        tbre = 1'b1;
  logic        tsre = 1'b1;
  logic [15:0] light;
  logic [17:0] Ram1Addr;
  wire  [15:0] Ram1Data;
  logic        Ram1OE;
  logic        Ram1WE;
  logic        Ram1EN;
  logic [17:0] Ram2Addr;
  wire  [15:0] Ram2Data;
  logic        Ram2OE;
  logic        Ram2WE;
  logic        Ram2EN;
  logic        wrn;
  logic        rdn;

  logic [15:0] mem_val  = 16'h1234;
  logic [15:0] uart_val = 16'h0041;

  assign Ram1Data = (!Ram1OE && !Ram1EN) ? mem_val :
                    (!rdn ? uart_val : 16'hzzzz);

  zz_cpu dut (
    .clk(clk), .rst(rst), .light(light), .l(l),
    .Ram1Addr(Ram1Addr), .Ram1Data(Ram1Data),
    .Ram1OE(Ram1OE), .Ram1WE(Ram1WE), .Ram1EN(Ram1EN),
    .Ram2Addr(Ram2Addr), .Ram2Data(Ram2Data),
    .Ram2OE(Ram2OE), .Ram2WE(Ram2WE), .Ram2EN(Ram2EN),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre),
    .wrn(wrn), .rdn(rdn)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {S_LIGHT, S_PC, S_ADDR, S_DATA, S_OE,
                S_WE, S_EN, S_WRN, S_RDN} sel_e;

  typedef struct {
    string       nm;
    int          key;
    sel_e        s;
    logic [17:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ex;
  logic [15:0] pc_x;

  function automatic logic [17:0] act(sel_e s);
    case (s)
      S_LIGHT: return {2'b00, light};
      S_PC:    return Ram2Addr;
      S_ADDR:  return Ram1Addr;
      S_DATA:  return {2'b00, Ram1Data};
      S_OE:    return {17'b0, Ram1OE};
      S_WE:    return {17'b0, Ram1WE};
      S_EN:    return {17'b0, Ram1EN};
      S_WRN:   return {17'b0, wrn};
      default: return {17'b0, rdn};
    endcase
  endfunction

  task automatic check(string nm, logic [17:0] a, logic [17:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic scan(int k);
    int i = 0;
    while (i < q.size()) begin
      if (q[i].key == k) begin
        check(q[i].nm, act(q[i].s), q[i].v);
        q.delete(i);
      end else if (q[i].key < k) begin
        checks++;
        errors++;
        $display("FAIL %s: not sampled, expected %h", q[i].nm, q[i].v);
        q.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1 scan(cyc * 2);
      @(negedge clk);
      #1 scan(cyc * 2 + 1);
    end
  end

  task automatic push(string nm, int c, bit h, sel_e s, logic [17:0] v);
    exp_t e;
    e.nm  = nm;
    e.key = c * 2 + int'(h);
    e.s   = s;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic issue(string nm, logic [15:0] ins, logic [15:0] off);
    @(negedge clk);
    l    = ins;
    ex   = cyc + 1;
    pc_x = pc_x + 16'd1 + off;
    push({nm, "_pc"}, ex + 1, 1'b0, S_PC, {2'b00, pc_x});
  endtask

  task automatic wb(string nm, logic [15:0] v);
    push({nm, "_light"}, ex + 1, 1'b0, S_LIGHT, {2'b00, v});
  endtask

  task automatic bus(string nm, bit h, sel_e s, logic [17:0] v);
    push(nm, ex, h, s, v);
  endtask

  task automatic abort(string nm, logic [15:0] ins, sel_e s,
                       logic [17:0] addr);
    @(negedge clk);
    l  = ins;
    ex = cyc + 1;
    bus({nm, "_addr"}, 1'b1, S_ADDR, addr);
    bus({nm, "_strobe"}, 1'b1, s, 18'h0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    l   = 16'h0800;
    #1;
    check({nm, "_we"}, {17'b0, Ram1WE}, 18'h1);
    check({nm, "_wrn"}, {17'b0, wrn}, 18'h1);
    check({nm, "_pc"}, Ram2Addr, 18'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    push("rst_light", cyc, 1'b1, S_LIGHT, 18'h0);
    push("rst_pc", cyc, 1'b1, S_PC, 18'h0);
    push("rst_oe", cyc, 1'b1, S_OE, 18'h1);
    push("rst_we", cyc, 1'b1, S_WE, 18'h1);
    push("rst_en", cyc, 1'b1, S_EN, 18'h0);
    push("rst_wrn", cyc, 1'b1, S_WRN, 18'h1);
    push("rst_rdn", cyc, 1'b1, S_RDN, 18'h1);
    @(negedge clk);
    rst  = 1'b1;
    pc_x = 16'd2;

    issue("li_r2", 16'h6AFF, 16'h0);     wb("li_r2", 16'h00FF);
    issue("nop", 16'h0800, 16'h0);       wb("nop", 16'h00FF);
    issue("li_r3", 16'h6BC0, 16'h0);     wb("li_r3", 16'h00C0);
    issue("sll8", 16'h3360, 16'h0);      wb("sll8", 16'hC000);
    issue("li_r1", 16'h6961, 16'h0);     wb("li_r1", 16'h0061);
    issue("addiu", 16'h4901, 16'h0);     wb("addiu", 16'h0062);
    issue("li_r5", 16'h6DFF, 16'h0);     wb("li_r5", 16'h00FF);
    issue("sll_r5", 16'h35A0, 16'h0);    wb("sll_r5", 16'hFF00);
    issue("addiu_neg", 16'h4D83, 16'h0); wb("addiu_neg", 16'hFE83);
    issue("sra1", 16'h36A7, 16'h0);      wb("sra1", 16'hFF41);
    issue("addu", 16'hE15D, 16'h0);      wb("addu", 16'h0161);
    issue("subu", 16'hE15F, 16'h0);      wb("subu", 16'hFF63);

    issue("sw_sram", 16'hDB02, 16'h0);   wb("sw_sram", 16'hFF63);
    bus("sw_addr", 1'b0, S_ADDR, 18'h0C002);
    bus("sw_data", 1'b0, S_DATA, 18'h0);
    bus("sw_we_hi", 1'b0, S_WE, 18'h1);
    bus("sw_we_lo", 1'b1, S_WE, 18'h0);
    bus("sw_en", 1'b1, S_EN, 18'h0);
    bus("sw_oe", 1'b1, S_OE, 18'h1);

    issue("lw_sram", 16'h9B82, 16'h0);   wb("lw_sram", 16'h1234);
    bus("lw_addr", 1'b0, S_ADDR, 18'h0C002);
    bus("lw_oe", 1'b1, S_OE, 18'h0);
    bus("lw_en", 1'b0, S_EN, 18'h0);
    bus("lw_we", 1'b1, S_WE, 18'h1);

    issue("bnez_t", 16'h2CFA, 16'hFFFA); wb("bnez_t", 16'h1234);
    issue("li_r4_0", 16'h6C00, 16'h0);   wb("li_r4_0", 16'h0000);
    issue("bnez_nt", 16'h2CFA, 16'h0);
    issue("beqz_t", 16'h2402, 16'h0002);
    issue("b_back", 16'h17FD, 16'hFFFD);
    issue("bad_op", 16'h8000, 16'h0);    wb("bad_op", 16'h0000);

    issue("li_r3bf", 16'h6BBF, 16'h0);   wb("li_r3bf", 16'h00BF);
    issue("sll_bf", 16'h3360, 16'h0);    wb("sll_bf", 16'hBF00);

    issue("sw_stat", 16'hDB41, 16'h0);   wb("sw_stat", 16'hBF00);
    bus("sw_stat_we", 1'b1, S_WE, 18'h1);
    bus("sw_stat_wrn", 1'b1, S_WRN, 18'h1);

    issue("sw_uart", 16'hDB40, 16'h0);
    bus("sw_uart_wrn_hi", 1'b0, S_WRN, 18'h1);
    bus("sw_uart_wrn_lo", 1'b1, S_WRN, 18'h0);
    bus("sw_uart_en", 1'b1, S_EN, 18'h1);
    bus("sw_uart_data", 1'b1, S_DATA, 18'h000FF);
    bus("sw_uart_we", 1'b1, S_WE, 18'h1);

    issue("lw_stat", 16'h9B81, 16'h0);   wb("lw_stat", 16'h0001);
    bus("lw_stat_rdn", 1'b1, S_RDN, 18'h1);
    bus("lw_stat_oe", 1'b1, S_OE, 18'h1);

    issue("lw_uart", 16'h9B80, 16'h0);   wb("lw_uart", 16'h0041);
    bus("lw_uart_rdn", 1'b1, S_RDN, 18'h0);
    bus("lw_uart_en", 1'b0, S_EN, 18'h1);
    bus("lw_uart_oe", 1'b0, S_OE, 18'h1);

    abort("abort_uart", 16'hDB40, S_WRN, 18'h0BF00);
    abort("abort_sram", 16'hDB02, S_WE, 18'h00002);

    repeat (3) @(negedge clk);
    #2;
    while (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: left unchecked, expected %h", q[0].nm, q[0].v);
      q.delete(0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zz_cpu.md
Name: zz_cpu

Overview:
- Minimal single-issue 16-bit MIPS16-style CPU for the FPGA lab board.
- Instructions come from the 16 switches `l`, not from memory: one instruction is sampled per clock and executed in the next cycle.
- Data memory is the external SRAM on the Ram1 bus. The UART shares that bus and is mapped at 0xBF00/0xBF01.
- The Ram2 bus only exports the PC. The LEDs show the last write-back value.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- light  output  16  last register write-back value
- l  input  16  instruction word (switches)
- Ram1Addr  output  18  data SRAM address = {2'b00, effective address}
- Ram1Data  inout  16  data SRAM / UART data bus
- Ram1OE, Ram1WE, Ram1EN  output  1 each  SRAM output-enable, write-enable, chip-enable (all active-low)
- Ram2Addr  output  18  {2'b00, PC}
- Ram2Data  inout  16  always high-Z
- Ram2OE, Ram2WE, Ram2EN  output  1 each  held at 1, 1, 1 (inactive)
- data_ready  input  1  UART receive data available
- tbre  input  1  UART transmit buffer empty
- tsre  input  1  UART transmit shift register empty
- wrn  output  1  UART write strobe (active-low)
- rdn  output  1  UART read strobe (active-low)

Behaviour:
- Reset (rst=0, asynchronous):
  - R0..R7 = 0, PC = 0, IR = 0x0800 (NOP), light = 0.
  - Ram1OE = Ram1WE = 1, Ram1EN = 0, wrn = rdn = 1, Ram1Data = Z.
- Pipeline:
  - At each rising edge, IR <= l.
  - During the following cycle, IR is decoded and executed combinationally, including the memory access.
  - At the next rising edge, the register write and PC update commit, and IR loads the next `l` at the same edge.
  - Throughput is one instruction per clock. The next instruction reads the already-updated register file, so there are no hazards.
- PC update: PC <= PC+1 every executed cycle, except a taken branch, where PC <= PC+1+sext(imm8). All 16-bit wrap-around.
- Field positions: rx = IR[10:8], ry = IR[7:5].
- Instructions (opcode = IR[15:11]):
  - 01101 LI: rx = zext(imm8).
  - 01001 ADDIU: rx = rx + sext(imm8).
  - 00110 SLL (IR[1:0] = 00): rx = ry << sa, where sa = IR[4:2] and sa = 0 means 8.
  - 00110 SRA (IR[1:0] = 11): rx = ry >>> sa, same sa rule.
  - 11100 ADDU (IR[1:0] = 01): rz = rx + ry, where rz = IR[4:2].
  - 11100 SUBU (IR[1:0] = 11): rz = rx - ry.
  - 10011 LW: ry = M[rx + sext(imm5)].
  - 11011 SW: M[rx + sext(imm5)] = ry.
  - 00101 BNEZ: branch if rx != 0.
  - 00100 BEQZ: branch if rx == 0.
  - 00010 B: always branch, using sext(imm11).
  - Every other encoding (e.g. 0x0800, 0x8000) is a NOP: PC += 1, no write-back, light unchanged.
- Arithmetic: 16-bit modulo, no flags, no exceptions.
- light updates on every register write with the written value.
- Memory map for effective address EA:
  - EA = 0xBF00: UART data.
  - EA = 0xBF01: UART status, reads {14'b0, data_ready, tbre & tsre}.
  - Any other EA: SRAM.
- SRAM LW cycle:
  - Ram1EN = 0, Ram1OE = 0, Ram1Data = Z.
  - Data is captured into ry at the ending rising edge.
- SRAM SW cycle:
  - Ram1EN = 0, Ram1Data = ry for the whole cycle.
  - Ram1WE = 0 only while clk is low (second half of the cycle), giving stable address and data before the strobe.
- UART read (LW 0xBF00):
  - Ram1EN = 1, Ram1OE = 1.
  - rdn = 0 for the whole cycle; data is captured at the ending edge.
- UART write (SW 0xBF00):
  - Ram1EN = 1, Ram1Data = ry.
  - wrn = 0 while clk is low.
- Status read (0xBF01): no bus strobe; the value is muxed internally. SW to 0xBF01 is ignored.
- Non-memory cycles: Ram1OE = Ram1WE = 1, Ram1EN = 0, wrn = rdn = 1, Ram1Data = Z.
- Reset mid-cycle: aborts any strobe immediately (all strobes forced inactive), and nothing commits.

Test Plan:
- Reset, then LI R2,FF (0x6AFF) and NOP: light = 0x00FF after the commit edge; R2 = 0x00FF.
- LI R3,C0 (0x6BC0) then SLL R3,R3,0 (0x3360): light = 0x00C0, then 0xC000.
- LI R1,0x61 (0x6961) then ADDIU R1,1 (0x4901) → R1 = 0x0062. Then ADDIU R5,0x83 (0x4D83) with R5 = 0xFF00 → R5 = 0xFE83 (sign-extended add).
- With R3 = 0xC000: SW R3,R0,2 (0xDB02) → Ram1Addr = 0x0C002, Ram1Data driven 0, Ram1WE low only in the clk-low half. Then LW R3,R4,2 (0x9B82) with the SRAM model returning 0x1234 → Ram1OE = 0, R4 = 0x1234.
- BNEZ R4,FA (0x2CFA): with R4 != 0, PC = 0x000D goes to 0x0008 (PC+1-6); with R4 = 0, PC goes to 0x000E. Check on Ram2Addr.
- R3 = 0xBF00:
  - SW R3,R2,1 (0xDB41, EA = 0xBF01): nothing happens.
  - SW R3,R2,0 (0xDB40, EA = 0xBF00): wrn pulses low, Ram1EN = 1.
  - LW R3,R4,1 (0x9B81) with tbre = tsre = 1 and data_ready = 0: R4 = 0x0001.
  - Asserting rst low mid-SW: Ram1WE and wrn go to 1 immediately.
